// File: rtl/sie_defs_pkg.sv
// Shared USB receive-side definitions: PID encoding, PID groups and decoder states.
package sie_defs_pkg;

    typedef enum logic [3:0] {
        PidOut   = 4'h1,
        PidAck   = 4'h2,
        PidData0 = 4'h3,
        PidPing  = 4'h4,
        PidSof   = 4'h5,
        PidNyet  = 4'h6,
        PidData2 = 4'h7,
        PidSplit = 4'h8,
        PidIn    = 4'h9,
        PidNak   = 4'hA,
        PidData1 = 4'hB,
        PidPre   = 4'hC,
        PidSetup = 4'hD,
        PidStall = 4'hE,
        PidMdata = 4'hF
    } pid_e;

    // One bit per PID[3:0] value.
    localparam logic [15:0] PidGrpToken     = 16'h2202; // OUT, IN, SETUP
    localparam logic [15:0] PidGrpData      = 16'h0808; // DATA0, DATA1
    localparam logic [15:0] PidGrpHandshake = 16'h4404; // ACK, NAK, STALL
    localparam logic [15:0] PidGrpSpecial   = 16'h1110; // PING, SPLIT, PRE/ERR

    typedef enum logic [2:0] {
        StIdle,
        StTok1,
        StTok2,
        StData,
        StDone,
        StDrop
    } dec_state_e;

    function automatic logic pid_in_group(input logic [3:0] pid, input logic [15:0] grp);
        return grp[pid];
    endfunction

endpackage

// File: rtl/usb_rx_crc_strip.sv
// Two-byte holdback that drops the trailing CRC16, plus a valid/accept output register.
module usb_rx_crc_strip (
    input  logic       clk12_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       push_last_i,
    input  logic       data_accept_i,
    output logic       data_valid_o,
    output logic [7:0] data_o,
    output logic       data_is_last_o,
    output logic       has_body_o
);

    logic [7:0] h0_q, h0_d, h1_q, h1_d;
    logic       h0_valid_q, h0_valid_d, h1_valid_q, h1_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;

    always_comb begin
        h0_d        = h0_q;
        h1_d        = h1_q;
        h0_valid_d  = h0_valid_q;
        h1_valid_d  = h1_valid_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && data_accept_i) begin
            out_valid_d = 1'b0;
        end

        if (clear_i) begin
            h0_valid_d = 1'b0;
            h1_valid_d = 1'b0;
        end else if (push_i) begin
            if (push_last_i) begin
                // h1 and the last byte are the CRC16; h0 is payload only if h1 exists.
                h0_valid_d = 1'b0;
                h1_valid_d = 1'b0;
                if (h0_valid_q && h1_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = h0_q;
                    out_last_d  = 1'b1;
                end
            end else if (h0_valid_q && h1_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = h0_q;
                out_last_d  = 1'b0;
                h0_d        = h1_q;
                h1_d        = push_data_i;
            end else if (h0_valid_q) begin
                h1_d       = push_data_i;
                h1_valid_d = 1'b1;
            end else begin
                h0_d       = push_data_i;
                h0_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            h0_q        <= 8'h00;
            h1_q        <= 8'h00;
            h0_valid_q  <= 1'b0;
            h1_valid_q  <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            h0_valid_q  <= h0_valid_d;
            h1_valid_q  <= h1_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign data_valid_o   = out_valid_q;
    assign data_o         = out_data_q;
    assign data_is_last_o = out_last_q;
    assign has_body_o     = h0_valid_q;

endmodule

// File: rtl/usb_packet_decoder.sv
// Classifies SIE receive packets into token/SOF/handshake events and a CRC-stripped payload.
module usb_packet_decoder
    import sie_defs_pkg::*;
(
    input  logic        clk12_i,
    input  logic        rst_i,
    input  logic [6:0]  deviceAddr_i,
    output logic        rxAcceptNewData_o,
    input  logic [7:0]  rxData_i,
    input  logic        rxIsLastByte_i,
    input  logic        rxDataValid_i,
    input  logic        keepPacket_i,
    output logic        tokenValid_o,
    output logic [3:0]  tokenPid_o,
    output logic [3:0]  tokenEndpoint_o,
    output logic        sofValid_o,
    output logic [10:0] frameNum_o,
    output logic        handshakeValid_o,
    output logic [3:0]  handshakePid_o,
    output logic [3:0]  dataPid_o,
    output logic        dataValid_o,
    output logic [7:0]  data_o,
    output logic        dataIsLast_o,
    input  logic        dataAccept_i,
    output logic        dataPacketDone_o,
    output logic        dataPacketOk_o,
    output logic        packetError_o
);

    dec_state_e  state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [7:0]  b1_q, b1_d;
    logic        addr_match_q, addr_match_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic        token_valid_q, token_valid_d;
    logic [3:0]  token_pid_q, token_pid_d;
    logic [3:0]  token_ep_q, token_ep_d;
    logic        sof_valid_q, sof_valid_d;
    logic [10:0] frame_num_q, frame_num_d;
    logic        hs_valid_q, hs_valid_d;
    logic [3:0]  hs_pid_q, hs_pid_d;
    logic [3:0]  data_pid_q, data_pid_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;

    logic       rx_fire, rx_pid_ok, rx_last;
    logic [3:0] rx_pid;
    logic       strip_clear, strip_push, strip_valid, strip_has_body;

    assign rx_fire   = rxDataValid_i && rxAcceptNewData_o;
    assign rx_pid    = rxData_i[3:0];
    assign rx_pid_ok = (rxData_i[7:4] == ~rxData_i[3:0]);
    assign rx_last   = rxIsLastByte_i;

    assign strip_clear = (state_q == StIdle) && rx_fire;
    assign strip_push  = (state_q == StData) && rx_fire;

    usb_rx_crc_strip u_crc_strip (
        .clk12_i        (clk12_i),
        .rst_i          (rst_i),
        .clear_i        (strip_clear),
        .push_i         (strip_push),
        .push_data_i    (rxData_i),
        .push_last_i    (rx_last),
        .data_accept_i  (dataAccept_i),
        .data_valid_o   (strip_valid),
        .data_o         (data_o),
        .data_is_last_o (dataIsLast_o),
        .has_body_o     (strip_has_body)
    );

    always_comb begin
        rxAcceptNewData_o = 1'b1;
        if (rst_i || state_q == StDone) begin
            rxAcceptNewData_o = 1'b0;
        end else if (state_q == StData && strip_valid && !dataAccept_i) begin
            rxAcceptNewData_o = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        pid_d         = pid_q;
        b1_d          = b1_q;
        addr_match_d  = addr_match_q;
        pkt_ok_d      = pkt_ok_q;
        token_valid_d = 1'b0;
        token_pid_d   = token_pid_q;
        token_ep_d    = token_ep_q;
        sof_valid_d   = 1'b0;
        frame_num_d   = frame_num_q;
        hs_valid_d    = 1'b0;
        hs_pid_d      = hs_pid_q;
        data_pid_d    = data_pid_q;
        done_d        = 1'b0;
        ok_d          = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    pid_d = rx_pid;
                    if (!rx_pid_ok) begin
                        err_d   = 1'b1;
                        state_d = rx_last ? StIdle : StDrop;
                    end else if (pid_in_group(rx_pid, PidGrpToken) || rx_pid == PidSof) begin
                        err_d   = rx_last;
                        state_d = rx_last ? StIdle : StTok1;
                    end else if (pid_in_group(rx_pid, PidGrpHandshake)) begin
                        if (!rx_last) begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end else if (keepPacket_i) begin
                            hs_valid_d = 1'b1;
                            hs_pid_d   = rx_pid;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (pid_in_group(rx_pid, PidGrpData)) begin
                        if (rx_last) begin
                            err_d = 1'b1;
                        end else begin
                            data_pid_d = rx_pid;
                            state_d    = StData;
                        end
                    end else begin
                        state_d = rx_last ? StIdle : StDrop;
                    end
                end
            end
            StTok1: begin
                if (rx_fire) begin
                    b1_d         = rxData_i;
                    addr_match_d = (rxData_i[6:0] == deviceAddr_i);
                    err_d        = rx_last;
                    state_d      = rx_last ? StIdle : StTok2;
                end
            end
            StTok2: begin
                if (rx_fire) begin
                    if (!rx_last) begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end else begin
                        state_d = StIdle;
                        if (!keepPacket_i) begin
                            err_d = 1'b1;
                        end else if (pid_q == PidSof) begin
                            sof_valid_d = 1'b1;
                            frame_num_d = {rxData_i[2:0], b1_q};
                        end else if (addr_match_q) begin
                            token_valid_d = 1'b1;
                            token_pid_d   = pid_q;
                            token_ep_d    = {rxData_i[2:0], b1_q[7]};
                        end
                    end
                end
            end
            StData: begin
                if (rx_fire && rx_last) begin
                    // At least one held body byte plus this one means length >= 3.
                    pkt_ok_d = keepPacket_i && strip_has_body;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!strip_valid || dataAccept_i) begin
                    done_d  = 1'b1;
                    ok_d    = pkt_ok_q;
                    err_d   = !pkt_ok_q;
                    state_d = StIdle;
                end
            end
            StDrop: begin
                if (rx_fire && rx_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk12_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            pid_q         <= 4'h0;
            b1_q          <= 8'h00;
            addr_match_q  <= 1'b0;
            pkt_ok_q      <= 1'b0;
            token_valid_q <= 1'b0;
            token_pid_q   <= 4'h0;
            token_ep_q    <= 4'h0;
            sof_valid_q   <= 1'b0;
            frame_num_q   <= 11'h000;
            hs_valid_q    <= 1'b0;
            hs_pid_q      <= 4'h0;
            data_pid_q    <= 4'h0;
            done_q        <= 1'b0;
            ok_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pid_q         <= pid_d;
            b1_q          <= b1_d;
            addr_match_q  <= addr_match_d;
            pkt_ok_q      <= pkt_ok_d;
            token_valid_q <= token_valid_d;
            token_pid_q   <= token_pid_d;
            token_ep_q    <= token_ep_d;
            sof_valid_q   <= sof_valid_d;
            frame_num_q   <= frame_num_d;
            hs_valid_q    <= hs_valid_d;
            hs_pid_q      <= hs_pid_d;
            data_pid_q    <= data_pid_d;
            done_q        <= done_d;
            ok_q          <= ok_d;
            err_q         <= err_d;
        end
    end

    assign tokenValid_o     = token_valid_q;
    assign tokenPid_o       = token_pid_q;
    assign tokenEndpoint_o  = token_ep_q;
    assign sofValid_o       = sof_valid_q;
    assign frameNum_o       = frame_num_q;
    assign handshakeValid_o = hs_valid_q;
    assign handshakePid_o   = hs_pid_q;
    assign dataPid_o        = data_pid_q;
    assign dataValid_o      = strip_valid;
    assign dataPacketDone_o = done_q;
    assign dataPacketOk_o   = ok_q;
    assign packetError_o    = err_q;

endmodule

// File: tb/tb_usb_packet_decoder.sv
// Directed bench for usb_packet_decoder: tokens, SOF, handshakes, data payloads, errors, reset.
module tb_usb_packet_decoder;

    logic        clk12_i = 1'b0;
    logic        rst_i;
    logic [6:0]  deviceAddr_i;
    logic        rxAcceptNewData_o;
    logic [7:0]  rxData_i;
    logic        rxIsLastByte_i;
    logic        rxDataValid_i;
    logic        keepPacket_i;
    logic        tokenValid_o;
    logic [3:0]  tokenPid_o;
    logic [3:0]  tokenEndpoint_o;
    logic        sofValid_o;
    logic [10:0] frameNum_o;
    logic        handshakeValid_o;
    logic [3:0]  handshakePid_o;
    logic [3:0]  dataPid_o;
    logic        dataValid_o;
    logic [7:0]  data_o;
    logic        dataIsLast_o;
    logic        dataAccept_i = 1'b0;
    logic        dataPacketDone_o;
    logic        dataPacketOk_o;
    logic        packetError_o;

    int checks = 0;
    int errors = 0;

    // Consumer-side observation, written only by the monitor process.
    logic [15:0] stall_pat = 16'hB2C5;
    logic [8:0]  pay_q[$];
    int          stall_seen = 0;
    int          stall_viol = 0;
    int          err_cnt = 0;
    int          tok_cnt = 0;
    int          sof_cnt = 0;
    int          hs_cnt = 0;

    always #5 clk12_i = ~clk12_i;

    usb_packet_decoder dut (
        .clk12_i          (clk12_i),
        .rst_i            (rst_i),
        .deviceAddr_i     (deviceAddr_i),
        .rxAcceptNewData_o(rxAcceptNewData_o),
        .rxData_i         (rxData_i),
        .rxIsLastByte_i   (rxIsLastByte_i),
        .rxDataValid_i    (rxDataValid_i),
        .keepPacket_i     (keepPacket_i),
        .tokenValid_o     (tokenValid_o),
        .tokenPid_o       (tokenPid_o),
        .tokenEndpoint_o  (tokenEndpoint_o),
        .sofValid_o       (sofValid_o),
        .frameNum_o       (frameNum_o),
        .handshakeValid_o (handshakeValid_o),
        .handshakePid_o   (handshakePid_o),
        .dataPid_o        (dataPid_o),
        .dataValid_o      (dataValid_o),
        .data_o           (data_o),
        .dataIsLast_o     (dataIsLast_o),
        .dataAccept_i     (dataAccept_i),
        .dataPacketDone_o (dataPacketDone_o),
        .dataPacketOk_o   (dataPacketOk_o),
        .packetError_o    (packetError_o)
    );

    always @(negedge clk12_i) begin
        stall_pat    = {stall_pat[14:0], stall_pat[15]};
        dataAccept_i = stall_pat[0];
        #1;
        if (dataValid_o && dataAccept_i) pay_q.push_back({dataIsLast_o, data_o});
        if (dataValid_o && !dataAccept_i) begin
            stall_seen++;
            if (rxAcceptNewData_o) stall_viol++;
        end
        if (packetError_o)    err_cnt++;
        if (tokenValid_o)     tok_cnt++;
        if (sofValid_o)       sof_cnt++;
        if (handshakeValid_o) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at negedge+2; returns at negedge+2 of the cycle after the byte transferred.
    task automatic send(input logic [7:0] b, input logic last, input logic keep);
        logic accepted;
        int   n;
        accepted       = 1'b0;
        n              = 0;
        rxData_i       = b;
        rxIsLastByte_i = last;
        keepPacket_i   = keep;
        rxDataValid_i  = 1'b1;
        while (!accepted && n < 100) begin
            if (rxAcceptNewData_o) accepted = 1'b1;
            @(negedge clk12_i);
            #2;
            n++;
        end
        rxDataValid_i  = 1'b0;
        rxIsLastByte_i = 1'b0;
        chk("byte_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!dataPacketDone_o && n < 40) begin
            @(negedge clk12_i);
            #2;
            n++;
        end
        chk("done_seen", {31'd0, dataPacketDone_o}, 32'd1);
    endtask

    task automatic idle_cycle();
        @(negedge clk12_i);
        #2;
    endtask

    initial begin
        int          base;
        int          e0;
        int          t0;
        logic [8:0]  exp_pay [3];
        exp_pay[0] = 9'h011;
        exp_pay[1] = 9'h022;
        exp_pay[2] = 9'h133;

        rst_i          = 1'b1;
        deviceAddr_i   = 7'd5;
        rxData_i       = 8'h00;
        rxIsLastByte_i = 1'b0;
        rxDataValid_i  = 1'b0;
        keepPacket_i   = 1'b0;
        repeat (2) @(negedge clk12_i);
        #2;
        chk("rst_accept", {31'd0, rxAcceptNewData_o}, 32'd0);
        chk("rst_token_valid", {31'd0, tokenValid_o}, 32'd0);
        chk("rst_frame", {21'd0, frameNum_o}, 32'd0);
        chk("rst_data_valid", {31'd0, dataValid_o}, 32'd0);
        chk("rst_error", {31'd0, packetError_o}, 32'd0);
        rst_i = 1'b0;
        idle_cycle();
        chk("idle_accept", {31'd0, rxAcceptNewData_o}, 32'd1);

        // IN token, addr 5, ep 0.
        send(8'h69, 1'b0, 1'b1);
        send(8'h05, 1'b0, 1'b1);
        send(8'h58, 1'b1, 1'b1);
        chk("in_valid", {31'd0, tokenValid_o}, 32'd1);
        chk("in_pid", {28'd0, tokenPid_o}, 32'h9);
        chk("in_ep", {28'd0, tokenEndpoint_o}, 32'h0);
        idle_cycle();
        chk("in_pulse_one", {31'd0, tokenValid_o}, 32'd0);

        // OUT token, addr 5, ep 5 (b1[7]=1, b2[2:0]=2).
        send(8'hE1, 1'b0, 1'b1);
        send(8'h85, 1'b0, 1'b1);
        send(8'hA2, 1'b1, 1'b1);
        chk("out_valid", {31'd0, tokenValid_o}, 32'd1);
        chk("out_pid", {28'd0, tokenPid_o}, 32'h1);
        chk("out_ep", {28'd0, tokenEndpoint_o}, 32'h5);

        // Same IN token to another device address: no event.
        deviceAddr_i = 7'd6;
        t0 = tok_cnt;
        send(8'h69, 1'b0, 1'b1);
        send(8'h05, 1'b0, 1'b1);
        send(8'h58, 1'b1, 1'b1);
        chk("in_other_addr", {31'd0, tokenValid_o}, 32'd0);
        idle_cycle();
        chk("in_other_cnt", tok_cnt - t0, 32'd0);
        deviceAddr_i = 7'd5;

        // SOF frame 0x234.
        send(8'hA5, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b1);
        send(8'h12, 1'b1, 1'b1);
        chk("sof_valid", {31'd0, sofValid_o}, 32'd1);
        chk("sof_frame", {21'd0, frameNum_o}, 32'h234);
        idle_cycle();
        chk("sof_pulse_one", {31'd0, sofValid_o}, 32'd0);
        chk("sof_frame_hold", {21'd0, frameNum_o}, 32'h234);

        // DATA1 with three payload bytes and consumer stalls.
        base = pay_q.size();
        send(8'h4B, 1'b0, 1'b1);
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b1, 1'b1);
        wait_done();
        chk("d1_ok", {31'd0, dataPacketOk_o}, 32'd1);
        chk("d1_no_err", {31'd0, packetError_o}, 32'd0);
        chk("d1_pid", {28'd0, dataPid_o}, 32'hB);
        idle_cycle();
        chk("d1_count", pay_q.size() - base, 32'd3);
        for (int i = 0; i < 3 && base + i < pay_q.size(); i++) begin
            chk("d1_byte", {23'd0, pay_q[base + i]}, {23'd0, exp_pay[i]});
        end
        chk("d1_stall_seen", {31'd0, stall_seen != 0}, 32'd1);
        chk("d1_stall_respected", stall_viol, 32'd0);

        // Zero-length DATA0.
        base = pay_q.size();
        send(8'hC3, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b1, 1'b1);
        wait_done();
        chk("zlp_ok", {31'd0, dataPacketOk_o}, 32'd1);
        chk("zlp_pid", {28'd0, dataPid_o}, 32'h3);
        idle_cycle();
        chk("zlp_no_payload", pay_q.size() - base, 32'd0);

        // DATA0 with only one byte after the PID: bad length.
        base = pay_q.size();
        send(8'hC3, 1'b0, 1'b1);
        send(8'h00, 1'b1, 1'b1);
        wait_done();
        chk("short_ok", {31'd0, dataPacketOk_o}, 32'd0);
        chk("short_err", {31'd0, packetError_o}, 32'd1);
        idle_cycle();
        chk("short_no_payload", pay_q.size() - base, 32'd0);

        // Corrupt PID then two bytes: one error, all bytes dropped.
        e0 = err_cnt;
        t0 = tok_cnt + sof_cnt + hs_cnt;
        send(8'h6A, 1'b0, 1'b1);
        chk("badpid_err", {31'd0, packetError_o}, 32'd1);
        send(8'h01, 1'b0, 1'b1);
        send(8'h02, 1'b1, 1'b1);
        idle_cycle();
        chk("badpid_err_once", err_cnt - e0, 32'd1);
        chk("badpid_no_event", tok_cnt + sof_cnt + hs_cnt - t0, 32'd0);

        // ACK with keep=0 then keep=1.
        send(8'hD2, 1'b1, 1'b0);
        chk("ack_bad_err", {31'd0, packetError_o}, 32'd1);
        chk("ack_bad_no_hs", {31'd0, handshakeValid_o}, 32'd0);
        send(8'hD2, 1'b1, 1'b1);
        chk("ack_hs", {31'd0, handshakeValid_o}, 32'd1);
        chk("ack_pid", {28'd0, handshakePid_o}, 32'h2);

        // Reset after the second byte of a DATA1 packet.
        send(8'h4B, 1'b0, 1'b1);
        send(8'h11, 1'b0, 1'b1);
        rst_i = 1'b1;
        idle_cycle();
        chk("mid_rst_datapid", {28'd0, dataPid_o}, 32'h0);
        chk("mid_rst_frame", {21'd0, frameNum_o}, 32'h0);
        chk("mid_rst_tokpid", {28'd0, tokenPid_o}, 32'h0);
        chk("mid_rst_hspid", {28'd0, handshakePid_o}, 32'h0);
        chk("mid_rst_accept", {31'd0, rxAcceptNewData_o}, 32'd0);
        rst_i = 1'b0;
        idle_cycle();
        e0 = err_cnt;
        send(8'h22, 1'b0, 1'b1);
        chk("rem_pid_err", {31'd0, packetError_o}, 32'd1);
        send(8'h33, 1'b0, 1'b1);
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b1, 1'b1);
        chk("rem_no_done", {31'd0, dataPacketDone_o}, 32'd0);
        send(8'h5A, 1'b1, 1'b1);
        chk("nak_hs", {31'd0, handshakeValid_o}, 32'd1);
        chk("nak_pid", {28'd0, handshakePid_o}, 32'hA);
        idle_cycle();
        chk("rem_err_once", err_cnt - e0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
